hazard_sched_ctrl: RTL

//  Issue/stall controller for the decode stage. Keeps a per-register scoreboard of in-flight

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_sched_ctrl_sb_entry.sv | 35 +++
 rtl/hazard_sched_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-stage hazard scheduler and its scoreboard.
package hazard_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PERF_W = 16;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]  sb_cnt_t;

    localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/hazard_sched_ctrl_sb_entry.sv
// One scoreboard counter: pending destination writes for a single architectural register.
module sb_entry
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    inc_i,
    input  logic    dec_i,
    output sb_cnt_t cnt_o,
    output logic    err_c
);

    sb_cnt_t cnt_q, cnt_d;

    // Simultaneous inc/dec nets to zero change; overflow and underflow hold the count and flag.
    always_comb begin
        cnt_d = cnt_q;
        err_c = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) err_c = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_c = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Decode-stage issue/stall controller with a per-register write scoreboard.
// HAZARD_FWD_EN: datapath forwards from EX/MEM, so only load-use stalls are raised.
module hazard_sched_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  reg_idx_t          id_rs,
    input  reg_idx_t          id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  reg_idx_t          id_rd,
    input  logic              id_flush,
    input  logic              wb_reg_write,
    input  reg_idx_t          wb_rd,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              issue,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              sb_err
);

    sb_cnt_t           cnt [NREG];
    logic [NREG-1:0]   nz_vec;
    logic [NREG-1:0]   err_vec;
    logic              inc_en, dec_en, hazard;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              sb_err_q, sb_err_d;

    assign inc_en = issue && id_reg_write && (id_rd != '0);
    assign dec_en = wb_reg_write && (wb_rd != '0);

    assign cnt[0]     = '0;
    assign nz_vec[0]  = 1'b0;
    assign err_vec[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_sb
        sb_entry u_sb (
            .clk   (clk),
            .rst_n (rst_n),
            .inc_i (inc_en && (id_rd == reg_idx_t'(i))),
            .dec_i (dec_en && (wb_rd == reg_idx_t'(i))),
            .cnt_o (cnt[i]),
            .err_c (err_vec[i])
        );
        assign nz_vec[i] = |cnt[i];
    end

`ifdef HAZARD_FWD_EN
    logic     ex_ld_v_q, ex_ld_v_d;
    reg_idx_t ex_ld_rd_q, ex_ld_rd_d;

    // Only a load issued last cycle cannot be forwarded in time.
    assign hazard = ex_ld_v_q &&
                    ((id_uses_rs && (id_rs != '0) && (id_rs == ex_ld_rd_q)) ||
                     (id_uses_rt && (id_rt != '0) && (id_rt == ex_ld_rd_q)));

    assign ex_ld_v_d  = issue && id_mem_read && id_reg_write && (id_rd != '0);
    assign ex_ld_rd_d = id_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ld_v_q  <= 1'b0;
            ex_ld_rd_q <= '0;
        end else begin
            ex_ld_v_q  <= ex_ld_v_d;
            ex_ld_rd_q <= ex_ld_rd_d;
        end
    end
`else
    logic unused_mem_read;
    assign unused_mem_read = id_mem_read;

    // Full interlock on registered counters; no write-through from WB.
    assign hazard = (id_uses_rs && (id_rs != '0) && (cnt[id_rs] != '0)) ||
                    (id_uses_rt && (id_rt != '0) && (cnt[id_rt] != '0));
`endif

    assign stall       = id_valid && !id_flush && hazard;
    assign issue       = id_valid && !id_flush && !stall;
    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign busy        = |nz_vec;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        sb_err_d    = sb_err_q | (|err_vec);
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign sb_err    = sb_err_q;

endmodule
